// File: rtl/riscv_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : riscv_decode_stage
// Purpose  : RV32I decode stage with register file, read bypass, stall snoop
//            and flush; one registered stage with valid/ready on both sides.
// Revision : 1.0  initial release
// ============================================================================
module riscv_decode_stage #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_inst_valid,
    output logic            o_inst_ready,
    input  logic [31:0]     i_inst,
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_flush,
    input  logic            i_wb_en,
    input  logic [4:0]      i_wb_rd,
    input  logic [XLEN-1:0] i_wb_data,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [6:0]      o_opcode,
    output logic [2:0]      o_funct3,
    output logic [6:0]      o_funct7,
    output logic [XLEN-1:0] o_num1,
    output logic [XLEN-1:0] o_num2,
    output logic [XLEN-1:0] o_imm_num,
    output logic [XLEN-1:0] o_pc,
    output logic [4:0]      o_rd,
    output logic            o_rd_we,
    output logic            o_illegal
);

    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_REG    = 7'b0110011;
    localparam logic [6:0] c_OP_FENCE  = 7'b0001111;
    localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;

    logic [XLEN-1:0] rf_q [32];

    logic            valid_q;
    logic [6:0]      opcode_q;
    logic [2:0]      funct3_q;
    logic [6:0]      funct7_q;
    logic [XLEN-1:0] num1_q, num2_q, imm_q, pc_q;
    logic [4:0]      rd_q, rs1_q, rs2_q;
    logic            rd_we_q, illegal_q;

    logic [6:0]      w_opcode;
    logic [4:0]      w_rd, w_rs1, w_rs2;
    logic [XLEN-1:0] w_imm, w_num1, w_num2;
    logic            w_legal, w_rd_we, w_capture;

    assign w_opcode     = i_inst[6:0];
    assign w_rd         = i_inst[11:7];
    assign w_rs1        = i_inst[19:15];
    assign w_rs2        = i_inst[24:20];
    assign o_inst_ready = ~valid_q | i_ready;
    assign w_capture    = i_inst_valid & o_inst_ready & ~i_flush;

    always_comb begin
        w_imm   = '0;
        w_legal = 1'b1;
        case (w_opcode)
            c_OP_IMM, c_OP_LOAD, c_OP_JALR:
                w_imm = {{20{i_inst[31]}}, i_inst[31:20]};
            c_OP_STORE:
                w_imm = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
            c_OP_BRANCH:
                w_imm = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25],
                         i_inst[11:8], 1'b0};
            c_OP_LUI, c_OP_AUIPC:
                w_imm = {i_inst[31:12], 12'b0};
            // JAL carries the absolute target so execute can redirect without an adder
            c_OP_JAL:
                w_imm = i_pc + {{11{i_inst[31]}}, i_inst[31], i_inst[19:12],
                                i_inst[20], i_inst[30:21], 1'b0};
            c_OP_REG, c_OP_FENCE, c_OP_SYSTEM:
                w_imm = '0;
            default:
                w_legal = 1'b0;
        endcase
    end

    assign w_rd_we = w_legal && (w_opcode != c_OP_BRANCH) && (w_opcode != c_OP_STORE)
                     && (w_rd != 5'd0);

    // Writeback in the same cycle is forwarded so the register file needs no write-first port
    always_comb begin
        w_num1 = '0;
        w_num2 = '0;
        if (w_rs1 != 5'd0)
            w_num1 = (i_wb_en && (i_wb_rd == w_rs1)) ? i_wb_data : rf_q[w_rs1];
        if (w_rs2 != 5'd0)
            w_num2 = (i_wb_en && (i_wb_rd == w_rs2)) ? i_wb_data : rf_q[w_rs2];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < 32; k++)
                rf_q[k] <= '0;
        end else if (i_wb_en && (i_wb_rd != 5'd0)) begin
            rf_q[i_wb_rd] <= i_wb_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_q   <= 1'b0;
            opcode_q  <= '0;
            funct3_q  <= '0;
            funct7_q  <= '0;
            num1_q    <= '0;
            num2_q    <= '0;
            imm_q     <= '0;
            pc_q      <= '0;
            rd_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_we_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else if (i_flush) begin
            valid_q <= 1'b0;
        end else if (w_capture) begin
            valid_q   <= 1'b1;
            opcode_q  <= w_opcode;
            funct3_q  <= i_inst[14:12];
            funct7_q  <= i_inst[31:25];
            num1_q    <= w_num1;
            num2_q    <= w_num2;
            imm_q     <= w_imm;
            pc_q      <= i_pc;
            rd_q      <= w_rd;
            rs1_q     <= w_rs1;
            rs2_q     <= w_rs2;
            rd_we_q   <= w_rd_we;
            illegal_q <= ~w_legal;
        end else if (i_ready) begin
            valid_q <= 1'b0;
        end else if (valid_q && i_wb_en && (i_wb_rd != 5'd0)) begin
            // Held bundle keeps its operands current while execute is stalled
            if (i_wb_rd == rs1_q)
                num1_q <= i_wb_data;
            if (i_wb_rd == rs2_q)
                num2_q <= i_wb_data;
        end
    end

    assign o_valid   = valid_q;
    assign o_opcode  = opcode_q;
    assign o_funct3  = funct3_q;
    assign o_funct7  = funct7_q;
    assign o_num1    = num1_q;
    assign o_num2    = num2_q;
    assign o_imm_num = imm_q;
    assign o_pc      = pc_q;
    assign o_rd      = rd_q;
    assign o_rd_we   = rd_we_q;
    assign o_illegal = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_decode_stage
// Purpose  : Directed vectors with a queued scoreboard for riscv_decode_stage.
// Revision : 1.0  initial release
// ============================================================================
module tb_riscv_decode_stage;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] n1;
        logic [31:0] n2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } bundle_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_valid, inst_ready, flush, wb_en, out_valid, ready;
    logic [31:0] inst, pc, wb_data;
    logic [4:0]  wb_rd;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [31:0] num1, num2, imm_num, out_pc;
    logic [4:0]  rd;
    logic        rd_we, illegal;

    int checks = 0;
    int errors = 0;
    bundle_t exp_q[$];

    always #5 clk = ~clk;

    riscv_decode_stage #(.XLEN(32)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_inst_valid(inst_valid), .o_inst_ready(inst_ready),
        .i_inst(inst), .i_pc(pc), .i_flush(flush),
        .i_wb_en(wb_en), .i_wb_rd(wb_rd), .i_wb_data(wb_data),
        .o_valid(out_valid), .i_ready(ready),
        .o_opcode(opcode), .o_funct3(funct3), .o_funct7(funct7),
        .o_num1(num1), .o_num2(num2), .o_imm_num(imm_num), .o_pc(out_pc),
        .o_rd(rd), .o_rd_we(rd_we), .o_illegal(illegal)
    );

    function automatic bundle_t mk(input logic [6:0] op, input logic [2:0] f3,
                                   input logic [6:0] f7, input logic [31:0] n1,
                                   input logic [31:0] n2, input logic [31:0] imm,
                                   input logic [31:0] p, input logic [4:0] r,
                                   input logic we, input logic ill);
        bundle_t b;
        b.opcode = op; b.f3 = f3; b.f7 = f7; b.n1 = n1; b.n2 = n2;
        b.imm = imm; b.pc = p; b.rd = r; b.we = we; b.ill = ill;
        return b;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] w, input logic [31:0] p,
                         input bit push, input bundle_t e);
        inst_valid = 1'b1;
        inst       = w;
        pc         = p;
        if (push)
            exp_q.push_back(e);
        step();
        inst_valid = 1'b0;
    endtask

    // Monitor: every bundle execute accepts must match the oldest expectation
    initial begin
        bundle_t a, e;
        forever begin
            @(negedge clk);
            if (out_valid && ready && !flush && !rst) begin
                a = mk(opcode, funct3, funct7, num1, num2, imm_num, out_pc, rd, rd_we, illegal);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_bundle: got pc=%h op=%h with nothing expected",
                             out_pc, opcode);
                end else begin
                    e = exp_q.pop_front();
                    if (a !== e) begin
                        errors++;
                        $display("FAIL bundle pc=%h: got op=%h f3=%h f7=%h n1=%h n2=%h imm=%h pc=%h rd=%0d we=%b ill=%b expected op=%h f3=%h f7=%h n1=%h n2=%h imm=%h pc=%h rd=%0d we=%b ill=%b",
                                 e.pc, a.opcode, a.f3, a.f7, a.n1, a.n2, a.imm, a.pc, a.rd, a.we, a.ill,
                                 e.opcode, e.f3, e.f7, e.n1, e.n2, e.imm, e.pc, e.rd, e.we, e.ill);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; inst_valid = 1'b0; inst = '0; pc = '0; flush = 1'b0;
        wb_en = 1'b0; wb_rd = '0; wb_data = '0; ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", {31'b0, out_valid}, 32'd0);
        check("reset_ready", {31'b0, inst_ready}, 32'd1);
        check("reset_imm", imm_num, 32'd0);
        check("reset_num1", num1, 32'd0);
        rst = 1'b0;
        step();

        // ADDI x1,x0,-1 then back-to-back JAL and BEQ
        issue(32'hFFF00093, 32'h100, 1'b1,
              mk(7'h13, 3'h0, 7'h7F, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h100, 5'd1, 1'b1, 1'b0));
        check("latency_valid", {31'b0, out_valid}, 32'd1);
        issue(32'h008000EF, 32'h200, 1'b1,
              mk(7'h6F, 3'h0, 7'h00, 32'h0, 32'h0, 32'h208, 32'h200, 5'd1, 1'b1, 1'b0));
        issue(32'hFE000EE3, 32'h40, 1'b1,
              mk(7'h63, 3'h0, 7'h7F, 32'h0, 32'h0, 32'hFFFFFFFC, 32'h40, 5'd29, 1'b0, 1'b0));
        step();

        // Bypass: ADD x4,x3,x3 while writing x3
        wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEADBEEF;
        issue(32'h00318233, 32'h300, 1'b1,
              mk(7'h33, 3'h0, 7'h00, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 32'h300, 5'd4, 1'b1, 1'b0));
        wb_en = 1'b0;
        step();

        // Stall snoop
        ready = 1'b0;
        issue(32'h00318233, 32'h304, 1'b1,
              mk(7'h33, 3'h0, 7'h00, 32'h12345678, 32'h12345678, 32'h0, 32'h304, 5'd4, 1'b1, 1'b0));
        check("stall_inst_ready", {31'b0, inst_ready}, 32'd0);
        wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'h12345678;
        step();
        wb_en = 1'b0;
        check("snoop_num1", num1, 32'h12345678);
        check("snoop_num2", num2, 32'h12345678);
        check("stall_pc_hold", out_pc, 32'h304);
        ready = 1'b1;
        step();

        // LUI and SW back-to-back
        issue(32'h123452B7, 32'h400, 1'b1,
              mk(7'h37, 3'h5, 7'h09, 32'h0, 32'h12345678, 32'h12345000, 32'h400, 5'd5, 1'b1, 1'b0));
        issue(32'hFE20AC23, 32'h404, 1'b1,
              mk(7'h23, 3'h2, 7'h7F, 32'h0, 32'h0, 32'hFFFFFFF8, 32'h404, 5'd24, 1'b0, 1'b0));
        // Illegal opcode 0x7F with rd = x10
        issue(32'h0000057F, 32'h500, 1'b1,
              mk(7'h7F, 3'h0, 7'h00, 32'h0, 32'h0, 32'h0, 32'h500, 5'd10, 1'b0, 1'b1));
        step();

        // Flush a held bundle while a new instruction and a writeback arrive
        ready = 1'b0;
        issue(32'hFFF00093, 32'h600, 1'b0, mk('0, '0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0));
        flush = 1'b1; ready = 1'b1; inst_valid = 1'b1; inst = 32'h008000EF; pc = 32'h604;
        wb_en = 1'b1; wb_rd = 5'd7; wb_data = 32'hCAFE0007;
        step();
        flush = 1'b0; inst_valid = 1'b0; wb_en = 1'b0;
        check("flush_valid", {31'b0, out_valid}, 32'd0);
        check("flush_no_capture_pc", out_pc, 32'h600);
        issue(32'h00738433, 32'h700, 1'b1,
              mk(7'h33, 3'h0, 7'h00, 32'hCAFE0007, 32'hCAFE0007, 32'h0, 32'h700, 5'd8, 1'b1, 1'b0));
        step();

        // Asynchronous reset with a held bundle
        wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'h00000055;
        step();
        wb_en = 1'b0;
        ready = 1'b0;
        issue(32'h00528333, 32'h800, 1'b0, mk('0, '0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0));
        check("pre_reset_num1", num1, 32'h00000055);
        #2 rst = 1'b1;
        #1;
        check("async_reset_valid", {31'b0, out_valid}, 32'd0);
        check("async_reset_num1", num1, 32'd0);
        check("async_reset_pc", out_pc, 32'd0);
        check("async_reset_ready", {31'b0, inst_ready}, 32'd1);
        step();
        rst = 1'b0; ready = 1'b1;
        issue(32'h00528333, 32'h804, 1'b1,
              mk(7'h33, 3'h0, 7'h00, 32'h0, 32'h0, 32'h0, 32'h804, 5'd6, 1'b1, 1'b0));

        for (int i = 0; i < 20 && exp_q.size() != 0; i++)
            step();
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
